// File: rtl/gamma_lut_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gamma_lut_load_ctrl
// Description : Sequences runtime reloads of a gamma corrector's per-plane LUT
//               write ports from a streaming table source.
//               - Owns the corrector's gcen bypass control.
//               - Forces bypass while the pipeline drains and a table is being
//                 rewritten.
//               - Re-enables correction only once every plane again holds a
//                 complete table.
// Ports       : clk, rstn              clock, synchronous active-low reset
//               user_gcen              host request for correction enabled
//               load_req/load_plane    start a table load for one plane
//               load_abort             abandon the load in progress
//               src_valid/src_data     table source stream, address order 0..N-1
//               src_ready              combinational accept for the source
//               lut0..2wren, lutval    LUT write ports (shared write value)
//               gcen                   gamma enable to corrector
//               load_busy              high in any state except IDLE
//               load_done              one-cycle pulse, table committed
//               load_err               one-cycle pulse, bad plane or abort
//               table_valid            per-plane complete-table flags
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_lut_load_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CP     = 3,
  parameter int LATENCY    = 4,
  parameter int INIT_VALID = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  user_gcen,
  input  logic                  load_req,
  input  logic [1:0]            load_plane,
  input  logic                  load_abort,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  lut0wren,
  output logic                  lut1wren,
  output logic                  lut2wren,
  output logic [DATA_WIDTH-1:0] lutval,
  output logic                  gcen,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [NUM_CP-1:0]     table_valid
);

  // Drain counter only has to hold LATENCY-1.
  localparam int                  CNT_W        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]    C_DRAIN_INIT = CNT_W'(LATENCY - 1);
  // Address counter is one bit wider than the table so it never wraps in WRITE.
  localparam logic [DATA_WIDTH:0] C_ADDR_LAST  = {1'b0, {DATA_WIDTH{1'b1}}};
  localparam logic [2:0]          C_NUM_CP     = 3'(NUM_CP);
  localparam logic [NUM_CP-1:0]   C_TV_INIT    = (INIT_VALID != 0) ? {NUM_CP{1'b1}} : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH:0]     addr_q;
  logic [1:0]              plane_q;
  logic [NUM_CP-1:0]       table_valid_q;
  logic [2:0]              wren_q;
  logic [DATA_WIDTH-1:0]   lutval_q;
  logic                    gcen_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    w_req_ok;
  logic                    w_beat;
  logic                    w_last;

  // Plane index is range-checked against the number of LUTs actually present.
  assign w_req_ok  = load_req & ({1'b0, load_plane} < C_NUM_CP);

  // Abort wins over a same-cycle beat: the source sees no ready in that cycle.
  assign src_ready = (state_q == S_WRITE) & ~load_abort;
  assign w_beat    = src_valid & src_ready;
  assign w_last    = w_beat & (addr_q == C_ADDR_LAST);

  // Next state is needed combinationally so that gcen drops the cycle right
  // after a load is accepted, not one cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_req_ok) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (load_abort) begin
          state_d = S_IDLE;
        end else if (w_last) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      plane_q       <= '0;
      table_valid_q <= C_TV_INIT;
      wren_q        <= '0;
      lutval_q      <= '0;
      gcen_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      // Uses the flags as they stand this cycle: after a commit, correction
      // returns one cycle after the load_done pulse.
      gcen_q  <= user_gcen & (&table_valid_q) & (state_d == S_IDLE);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wren_q  <= '0;

      case (state_q)
        S_IDLE: begin
          if (w_req_ok) begin
            plane_q <= load_plane;
            cnt_q   <= C_DRAIN_INIT;
            for (int i = 0; i < NUM_CP; i++) begin
              if (load_plane == 2'(i)) begin
                table_valid_q[i] <= 1'b0;
              end
            end
          end else if (load_req) begin
            err_q <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (load_abort) begin
            err_q <= 1'b1;
          end else if (cnt_q == '0) begin
            addr_q <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_WRITE: begin
          if (load_abort) begin
            err_q <= 1'b1;
          end else if (w_beat) begin
            wren_q[plane_q] <= 1'b1;
            lutval_q        <= src_data;
            addr_q          <= addr_q + 1'b1;
          end
        end

        // The final write pulse is visible on the outputs during this state.
        S_SETTLE: begin
        end

        S_DONE: begin
          done_q <= 1'b1;
          for (int i = 0; i < NUM_CP; i++) begin
            if (plane_q == 2'(i)) begin
              table_valid_q[i] <= 1'b1;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  // Write enables for planes that do not exist are tied off.
  assign lut0wren = wren_q[0];

  generate
    if (NUM_CP >= 2) begin : g_lut1_en
      assign lut1wren = wren_q[1];
    end else begin : g_lut1_tie
      assign lut1wren = 1'b0;
    end

    if (NUM_CP >= 3) begin : g_lut2_en
      assign lut2wren = wren_q[2];
    end else begin : g_lut2_tie
      assign lut2wren = 1'b0;
    end
  endgenerate

  assign lutval      = lutval_q;
  assign gcen        = gcen_q;
  assign load_busy   = busy_q;
  assign load_done   = done_q;
  assign load_err    = err_q;
  assign table_valid = table_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gamma_lut_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gamma_lut_load_ctrl
// Description : Self-checking bench for gamma_lut_load_ctrl. Accepted source
//               beats are queued with their target plane; every LUT write
//               pops and compares against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gamma_lut_load_ctrl;

  localparam int DW  = 8;
  localparam int NCP = 3;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          user_gcen;
  logic          load_req;
  logic [1:0]    load_plane;
  logic          load_abort;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          lut0wren, lut1wren, lut2wren;
  logic [DW-1:0] lutval;
  logic          gcen;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [NCP-1:0] table_valid;

  gamma_lut_load_ctrl #(
    .DATA_WIDTH (DW),
    .NUM_CP     (NCP),
    .LATENCY    (LAT),
    .INIT_VALID (1)
  ) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .user_gcen   (user_gcen),
    .load_req    (load_req),
    .load_plane  (load_plane),
    .load_abort  (load_abort),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .lut0wren    (lut0wren),
    .lut1wren    (lut1wren),
    .lut2wren    (lut2wren),
    .lutval      (lutval),
    .gcen        (gcen),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .table_valid (table_valid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  exp_q[$];
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [9:0]  mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: each LUT write must match the oldest accepted beat.
  always @(posedge clk) begin
    #1;
    if (lut0wren | lut1wren | lut2wren) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_plane", {29'd0, lut2wren, lut1wren, lut0wren}, 32'd1 << mon_e[9:8]);
        check("wr_value", 32'(lutval), 32'(mon_e[7:0]));
      end
    end
    if (load_done) done_cnt++;
    if (load_err)  err_cnt++;
  end

  // One load from plane request to completion / abort / reset.
  task automatic run_load(input logic [1:0] plane, input bit gaps,
                          input int abort_after, input int rst_after,
                          input int busy_req_at);
    int         accepted = 0;
    int         drain = 0;
    int         ready_cycles = 0;
    int         it = 0;
    int         wr0 = wr_cnt;
    int         d0 = done_cnt;
    int         e0 = err_cnt;
    bit         seen_ready = 0;
    bit         aborted = 0;
    bit         reset_hit = 0;
    logic [7:0] val = 8'd0;

    @(negedge clk);
    load_req   = 1'b1;
    load_plane = plane;
    @(negedge clk);
    load_req = 1'b0;
    check("gcen_bypass", 32'(gcen), 32'd0);
    check("busy_on", 32'(load_busy), 32'd1);

    while (accepted < 256 && !aborted && !reset_hit && it < 2000) begin
      it++;
      load_req  = 1'b0;
      src_valid = gaps ? it[0] : 1'b1;
      src_data  = val;
      if (busy_req_at >= 0 && accepted == busy_req_at && seen_ready) begin
        load_req   = 1'b1;
        load_plane = 2'd0;
      end
      if (abort_after >= 0 && accepted == abort_after && seen_ready) begin
        src_valid  = 1'b1;
        load_abort = 1'b1;
        #1;
        check("abort_ready", 32'(src_ready), 32'd0);
        aborted = 1;
      end else if (rst_after >= 0 && accepted == rst_after && seen_ready) begin
        src_valid = 1'b1;
        rstn      = 1'b0;
        reset_hit = 1;
      end else begin
        #1;
        if (src_ready) begin
          seen_ready = 1;
          ready_cycles++;
        end else if (!seen_ready) begin
          drain++;
        end
        if (src_valid && src_ready) begin
          exp_q.push_back({plane, val});
          accepted++;
          val++;
        end
      end
      @(negedge clk);
    end
    src_valid  = 1'b0;
    load_abort = 1'b0;
    load_req   = 1'b0;
    check("drain_cycles", 32'(drain), 32'(LAT));

    if (aborted) begin
      check("abort_err", 32'(load_err), 32'd1);
      check("abort_busy", 32'(load_busy), 32'd0);
      check("abort_tv", 32'(table_valid[plane]), 32'd0);
      check("abort_gcen", 32'(gcen), 32'd0);
      repeat (4) @(negedge clk);
      check("abort_gcen_hold", 32'(gcen), 32'd0);
      check("abort_writes", 32'(wr_cnt - wr0), 32'(abort_after));
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("abort_err_once", 32'(err_cnt - e0), 32'd1);
    end else if (reset_hit) begin
      check("rst_wren", {29'd0, lut2wren, lut1wren, lut0wren}, 32'd0);
      check("rst_busy", 32'(load_busy), 32'd0);
      check("rst_tv", 32'(table_valid), 32'(3'b111));
      check("rst_gcen", 32'(gcen), 32'd0);
      check("rst_ready", 32'(src_ready), 32'd0);
      check("rst_writes", 32'(wr_cnt - wr0), 32'(rst_after));
      rstn = 1'b1;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      check("rst_gcen_back", 32'(gcen), 32'd1);
    end else begin
      check("load_beats", 32'(accepted), 32'd256);
      if (!gaps) check("ready_cycles", 32'(ready_cycles), 32'd256);
      check("settle_ready", 32'(src_ready), 32'd0);
      for (int k = 0; k < 10 && done_cnt == d0; k++) @(negedge clk);
      check("done_seen", 32'(done_cnt - d0), 32'd1);
      check("done_tv", 32'(table_valid), 32'(3'b111));
      check("done_busy", 32'(load_busy), 32'd0);
      @(negedge clk);
      check("gcen_restored", 32'(gcen), 32'd1);
      repeat (20) @(negedge clk);
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("write_count", 32'(wr_cnt - wr0), 32'd256);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("no_err", 32'(err_cnt - e0), 32'd0);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    user_gcen  = 1'b1;
    load_req   = 1'b0;
    load_plane = 2'd0;
    load_abort = 1'b0;
    src_valid  = 1'b0;
    src_data   = '0;

    repeat (3) @(negedge clk);
    check("reset_gcen", 32'(gcen), 32'd0);
    check("reset_tv", 32'(table_valid), 32'(3'b111));
    check("reset_busy", 32'(load_busy), 32'd0);
    check("reset_wren", {29'd0, lut2wren, lut1wren, lut0wren}, 32'd0);
    check("reset_lutval", 32'(lutval), 32'd0);
    check("reset_pulses", {30'd0, load_done, load_err}, 32'd0);
    check("reset_ready", 32'(src_ready), 32'd0);

    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("gcen_after_reset", 32'(gcen), 32'd1);
    check("busy_idle", 32'(load_busy), 32'd0);

    // Full streaming load, then a gapped load with a stray request mid-write.
    run_load(2'd1, 1'b0, -1, -1, -1);
    run_load(2'd1, 1'b1, -1, -1, 30);

    // Out-of-range plane.
    begin
      int e0 = err_cnt;
      @(negedge clk);
      load_req   = 1'b1;
      load_plane = 2'd3;
      @(negedge clk);
      load_req = 1'b0;
      check("badplane_err", 32'(load_err), 32'd1);
      check("badplane_busy", 32'(load_busy), 32'd0);
      check("badplane_gcen", 32'(gcen), 32'd1);
      @(negedge clk);
      check("badplane_pulse", 32'(err_cnt - e0), 32'd1);
      check("badplane_tv", 32'(table_valid), 32'(3'b111));
      check("badplane_idle", 32'(load_busy), 32'd0);
    end

    // Abort after 100 beats, then a clean reload restores correction.
    run_load(2'd1, 1'b0, 100, -1, -1);
    run_load(2'd1, 1'b0, -1, -1, -1);

    // Reset in the middle of writing plane 2.
    run_load(2'd2, 1'b0, -1, 50, -1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/gamma_lut_load_ctrl.md
Name: gamma_lut_load_ctrl

Overview:
Controller that sequences runtime reloads of the gamma corrector's per-plane LUT write ports (lutNwren/lutNval) from a streaming table source.
It also owns the corrector's gcen bypass control, forcing bypass while a table is being drained and rewritten, and re-enabling correction only when every plane holds a complete table.
Sits between the host/config logic and the gamma corrector instance, one per corrector.

Parameters:
DATA_WIDTH, 8, color-plane width; each table has 2^DATA_WIDTH entries of DATA_WIDTH bits
NUM_CP, 3, number of color planes / LUTs (1..3)
LATENCY, 4, corrector pipeline depth; drain cycles inserted before the first write (>=1)
INIT_VALID, 1, reset value of every per-plane table_valid flag (1 = LUTs preloaded from init files)

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
user_gcen  in  1  host request for gamma correction enabled
load_req  in  1  start a table load (sampled only in IDLE)
load_plane  in  2  target plane for load_req
load_abort  in  1  abandon load in progress
src_valid  in  1  table source data valid
src_data  in  DATA_WIDTH  table entry, ascending address order from 0
src_ready  out  1  controller accepts src_data this cycle
lut0wren  out  1  plane-0 LUT write enable
lut1wren  out  1  plane-1 LUT write enable (tie-off 0 if NUM_CP<2)
lut2wren  out  1  plane-2 LUT write enable (tie-off 0 if NUM_CP<3)
lutval  out  DATA_WIDTH  shared LUT write value, fans out to all lutNval
gcen  out  1  gamma enable to corrector
load_busy  out  1  high in any state except IDLE
load_done  out  1  one-cycle pulse, table committed
load_err  out  1  one-cycle pulse, bad plane or abort
table_valid  out  NUM_CP  per-plane complete-table flags

Behaviour:
- Reset (rstn=0 at clk edge): state=IDLE, src_ready/lutNwren/load_busy/load_done/load_err=0, lutval=0, table_valid={NUM_CP{INIT_VALID}}, gcen=0 (registered).
- All outputs are registered except src_ready, which is combinational from state and load_abort.
- gcen is registered: gcen <= user_gcen & (&table_valid) & (next state==IDLE). Bypass therefore takes effect the cycle after load_req is accepted.
- States: IDLE, DRAIN, WRITE, SETTLE, DONE.
- IDLE, load_req=1, load_plane<NUM_CP:
  - table_valid[plane] <= 0; latch plane; drain counter <= LATENCY-1; -> DRAIN.
- IDLE, load_req=1, load_plane>=NUM_CP: load_err pulse next cycle; stay IDLE; no flags change.
- load_req outside IDLE is ignored (no queueing).
- DRAIN: counter decrements each cycle; at counter==0 -> WRITE, addr counter <= 0. Total DRAIN time is LATENCY cycles.
- WRITE:
  - src_ready = ~load_abort.
  - On each src_valid & src_ready beat: next cycle lutNwren[plane]=1 and lutval=src_data; addr increments.
  - No beat: lutNwren=0 next cycle; lutval holds its last value.
  - Beat with addr==2^DATA_WIDTH-1 -> SETTLE. addr is DATA_WIDTH+1 bits and must not wrap inside the state.
- SETTLE: one cycle, carrying the final lutNwren pulse -> DONE.
- DONE: load_done pulse next cycle; table_valid[plane] <= 1; -> IDLE.
- load_abort in DRAIN or WRITE:
  - Takes priority over any same-cycle beat; that beat is not accepted (src_ready=0).
  - -> IDLE; load_err pulse; table_valid[plane] stays 0, so gcen stays 0 until that plane reloads successfully.
- load_abort in IDLE, SETTLE or DONE is ignored.
- Exactly one lutNwren may be high in any cycle, and only for the latched plane.
- Synchronous reset mid-load: the LUT is left partially written, and table_valid reverts to INIT_VALID. Host must reload if INIT_VALID=1 content matters.

Test Plan:
- Reset, user_gcen=1, INIT_VALID=1, DATA_WIDTH=8: gcen=1 from 2nd cycle after rstn rise; table_valid=3'b111; load_busy=0.
- load_req plane 1, LATENCY=4, src streams 0..255 with no gaps: gcen falls the next cycle; 4 DRAIN cycles; src_ready high for exactly 256 cycles; lut1wren high for 256 cycles with lutval=0..255; lut0wren/lut2wren stay 0; load_done pulses once; gcen returns to 1.
- Same load with src_valid toggling 1/0: exactly 256 lut1wren pulses in ascending value order; no write occurs in a cycle following src_valid=0.
- Abort after 100 accepted beats, with src_valid=1 in the abort cycle: that beat is not accepted; load_err pulses; table_valid[1]=0; gcen=0. A following full reload sets gcen=1.
- load_req with load_plane=3, NUM_CP=3: load_err pulses; state stays IDLE; gcen unchanged. load_req asserted while busy is ignored, with no second load_done.
- rstn=0 during WRITE at addr 50: all wren=0 and state IDLE on the next edge; table_valid=INIT_VALID.
